switch_debounce: RTL and testbench
==================================

# switch_debounce

Upstream conditioning stage for the slide-switch PIO. Takes the 8 raw, asynchronous, bouncing switch lines from the board pins and produces a synchronized, debounced 8-bit word. That word drives the PIO's `in_port`, so software reads only settled switch values. Per-bit change pulses and an all-settled flag are also provided for interrupt or edge-capture logic.

## Interface
- `WIDTH`, 8, number of switch lines.
- `DEBOUNCE_CYCLES`, 500000, consecutive clock edges a new level must persist before it is accepted. This is 10 ms at 50 MHz. Legal range is 1 to 2^CNT_WIDTH.
- `CNT_WIDTH`, 20, width of each per-bit debounce counter.

- `clk`  in  1  system clock; all state is on the rising edge.
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `sw_raw`  in  WIDTH  raw switch pins; asynchronous to `clk`.
- `sw_clean`  out  WIDTH  debounced switch word; connects to the PIO `in_port`.
- `sw_changed`  out  WIDTH  one-cycle pulse per bit, asserted in the same cycle that the bit of `sw_clean` toggles.
- `sw_stable`  out  1  high when every bit is settled, i.e. no bit has a pending mismatch.

## Operation
- **Synchronizer.** Each bit passes through a two-flop synchronizer: `sw_raw` → `s1` → `s2`. Only `s2` is used downstream.
- **Per-bit debounce.** Each bit i has its own counter `cnt[i]` (CNT_WIDTH bits) and its own state bit `sw_clean[i]`. On every rising edge:
  - If `s2[i] == sw_clean[i]`:
    - `cnt[i]` ← 0.
    - `sw_changed[i]` ← 0.
  - Else, if `cnt[i] == DEBOUNCE_CYCLES-1`:
    - `sw_clean[i]` ← `s2[i]`.
    - `cnt[i]` ← 0.
    - `sw_changed[i]` ← 1.
  - Else:
    - `cnt[i]` ← `cnt[i]+1`.
    - `sw_changed[i]` ← 0.
- **Accept rule.** A new level is accepted on the DEBOUNCE_CYCLES-th consecutive edge at which `s2[i]` differs from `sw_clean[i]`.
- **Bounce handling.** Any edge at which the mismatch disappears resets the count to 0. The partial count is discarded, not held.
- **Bit independence.** Bits are fully independent. Several bits may toggle in the same cycle, each with its own `sw_changed` pulse.
- **Stable flag.** `sw_stable` is registered. On each edge it is loaded with 1 when, for all i, `s2[i] == sw_clean[i]`; otherwise it is loaded with 0.
- **Counter width.** No counter ever exceeds DEBOUNCE_CYCLES-1, so a counter never wraps.
- **DEBOUNCE_CYCLES = 1.** A bit is accepted on the first mismatching edge.

## Timing
- **Reset values.** While `reset_n` is low, all of the following are 0 asynchronously:
  - `s1`, `s2`, `cnt`
  - `sw_clean`, `sw_changed`, `sw_stable`
- **Switches high at reset release.** Any switch already high when reset is released is treated as a normal 0→1 transition. Its `sw_clean` rises DEBOUNCE_CYCLES+2 edges after release, with a `sw_changed` pulse.
- **Latency.** Suppose `sw_raw[i]` changes and holds before edge 1. Then:
  - `s2[i]` reflects the change after edge 2.
  - The first mismatching edge is edge 3.
  - `sw_clean[i]` and `sw_changed[i]` update at edge DEBOUNCE_CYCLES+2.
  - `sw_changed[i]` clears at the following edge.
- **Minimum accepted pulse.** A raw pulse must last at least DEBOUNCE_CYCLES cycles, as seen at `s2`, to be accepted. Shorter pulses never reach `sw_clean`.
- **`sw_stable` timing.**
  - It drops one edge after `s2` first mismatches.
  - It returns high at the edge after `sw_clean` updates. This is the same edge at which `sw_changed` clears.
- **Reset mid-count.** A reset during a count clears all state immediately. After release, counting restarts from 0.
- **Output glitches.** No output is combinational from `sw_raw`.

## Test plan
All directed tests use DEBOUNCE_CYCLES=4 unless noted.
- **Reset.** Hold `reset_n` low with `sw_raw`=8'hFF, then release. Required response:
  - All outputs are 0 during reset.
  - `sw_clean` becomes 8'hFF at edge 6 after release.
  - `sw_changed` = 8'hFF for exactly one cycle at edge 6.
- **Clean step.** With `sw_clean`=8'h00, set `sw_raw`=8'h05 before edge 1. Required response:
  - `sw_clean`=8'h05 at edge 6, with `sw_changed`=8'h05 for one cycle.
  - `sw_stable` is 0 from edge 3 through edge 6 and 1 at edge 7.
- **Bounce rejection.** Toggle bit 0 high for 3 cycles, low for 2, high for 3, then low. Required response: `sw_clean[0]` stays 0 and `sw_changed` stays 0.
- **Bounce then settle.** Same bounce as above, then hold bit 0 high. Required response: `sw_clean[0]` goes to 1 exactly 4 edges after the first mismatching `s2` edge of the final high level.
- **Independent bits.** Raise bit 7 at cycle 0 and bit 3 at cycle 2, both held. Required response:
  - `sw_clean[7]` rises at edge 6; `sw_clean[3]` rises at edge 8.
  - Two separate one-cycle `sw_changed` pulses are seen.
- **Reset mid-count and minimum depth.**
  - Assert `reset_n` at edge 4 of a pending bit-2 transition, then release. Required response: the transition completes at edge 6 after release, not earlier.
  - Rerun with DEBOUNCE_CYCLES=1. Required response: `sw_clean` follows `sw_raw` with 3 edges of latency.

Source files
------------

// File: rtl/switch_debounce.sv
// Synchronizes and debounces the raw slide-switch lines feeding the PIO in_port.
// Each bit runs its own mismatch counter; a level is accepted after DEBOUNCE_CYCLES consecutive mismatches.
module switch_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  output logic             sw_stable
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     s1;
  logic [WIDTH-1:0]     s2;
  logic [CNT_WIDTH-1:0] cnt [WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Any edge without a mismatch discards the partial count rather than holding it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_clean   <= '0;
      sw_changed <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == sw_clean[i]) begin
          cnt[i]        <= '0;
          sw_changed[i] <= 1'b0;
        end else if (cnt[i] == CNT_LAST) begin
          sw_clean[i]   <= s2[i];
          cnt[i]        <= '0;
          sw_changed[i] <= 1'b1;
        end else begin
          cnt[i]        <= cnt[i] + 1'b1;
          sw_changed[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_stable <= 1'b0;
    end else begin
      sw_stable <= (s2 == sw_clean);
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: two instances (4-cycle and 1-cycle debounce) checked every edge
// against a sliding-window model of the accept rule, plus directed edge-count checks.
module tb_switch_debounce;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sw_raw = 8'h00;
  logic [7:0] clean4, chg4, clean1, chg1;
  logic       stab4, stab1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  switch_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) dut4 (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
    .sw_clean(clean4), .sw_changed(chg4), .sw_stable(stab4)
  );

  switch_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
    .sw_clean(clean1), .sw_changed(chg1), .sw_stable(stab1)
  );

  // Model: history of raw samples per edge since reset, and of the synchronized value seen at each edge.
  int         dcy [2] = '{4, 1};
  logic [7:0] rawq [$];
  logic [7:0] s2q  [$];
  logic [7:0] m_clean [2];
  logic [7:0] m_chg   [2];
  logic       m_stab  [2];

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    rawq.delete();
    s2q.delete();
    for (int k = 0; k < 2; k++) begin
      m_clean[k] = '0;
      m_chg[k]   = '0;
      m_stab[k]  = 1'b0;
    end
  endfunction

  // A bit flips when the last D synchronized samples all disagree with the current clean value.
  function automatic void model_edge();
    logic [7:0] s2u;
    logic [7:0] nc;
    bit         all_diff;
    s2u = (rawq.size() >= 2) ? rawq[rawq.size()-2] : 8'h00;
    rawq.push_back(sw_raw);
    s2q.push_back(s2u);
    if (rawq.size() > 16) void'(rawq.pop_front());
    if (s2q.size() > 16) void'(s2q.pop_front());
    for (int k = 0; k < 2; k++) begin
      nc = m_clean[k];
      for (int b = 0; b < 8; b++) begin
        all_diff = (s2q.size() >= dcy[k]);
        for (int j = 0; j < dcy[k] && all_diff; j++) begin
          if (s2q[s2q.size()-1-j][b] == m_clean[k][b]) all_diff = 1'b0;
        end
        if (all_diff) nc[b] = ~m_clean[k][b];
      end
      m_stab[k]  = (s2u == m_clean[k]);
      m_chg[k]   = nc ^ m_clean[k];
      m_clean[k] = nc;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    check_eq("clean4",  clean4,        m_clean[0]);
    check_eq("chg4",    chg4,          m_chg[0]);
    check_eq("stable4", {7'b0, stab4}, {7'b0, m_stab[0]});
    check_eq("clean1",  clean1,        m_clean[1]);
    check_eq("chg1",    chg1,          m_chg[1]);
    check_eq("stable1", {7'b0, stab1}, {7'b0, m_stab[1]});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_clean4",  clean4,        8'h00);
    check_eq("rst_chg4",    chg4,          8'h00);
    check_eq("rst_stable4", {7'b0, stab4}, 8'h00);
    check_eq("rst_clean1",  clean1,        8'h00);
    check_eq("rst_chg1",    chg1,          8'h00);
    check_eq("rst_stable1", {7'b0, stab1}, 8'h00);
    #1 reset_n = 1'b1;
  endtask

  logic [7:0] seen;

  initial begin
    // Switches high through reset: accepted at edge 6 (D=4) and edge 3 (D=1).
    sw_raw = 8'hFF;
    do_reset();
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 2) check_eq("rst_d1_e2", clean1, 8'h00);
      if (e == 3) check_eq("rst_d1_e3", clean1, 8'hFF);
      if (e == 5) check_eq("rst_d4_e5", clean4, 8'h00);
      if (e == 6) begin
        check_eq("rst_d4_e6", clean4, 8'hFF);
        check_eq("rst_chg_e6", chg4, 8'hFF);
      end
      if (e == 7) check_eq("rst_chg_e7", chg4, 8'h00);
    end

    // Clean step 00 -> 05.
    sw_raw = 8'h00;
    do_reset();
    repeat (3) step();
    sw_raw = 8'h05;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 2) check_eq("step_stab_e2", {7'b0, stab4}, 8'h01);
      if (e >= 3 && e <= 6) check_eq("step_stab_lo", {7'b0, stab4}, 8'h00);
      if (e == 5) check_eq("step_e5", clean4, 8'h00);
      if (e == 6) begin
        check_eq("step_e6", clean4, 8'h05);
        check_eq("step_chg_e6", chg4, 8'h05);
      end
      if (e == 7) begin
        check_eq("step_stab_e7", {7'b0, stab4}, 8'h01);
        check_eq("step_chg_e7", chg4, 8'h00);
      end
    end

    // Bounce rejection on bit 0: high 3, low 2, high 3, low.
    sw_raw = 8'h00;
    repeat (6) step();
    seen = 8'h00;
    for (int c = 0; c < 16; c++) begin
      sw_raw = ((c < 3) || (c >= 5 && c < 8)) ? 8'h01 : 8'h00;
      step();
      seen = seen | clean4 | chg4;
    end
    check_eq("bounce_reject", seen, 8'h00);

    // Bounce then settle: final high level held; accepted at its edge 6.
    for (int c = 0; c < 11; c++) begin
      sw_raw = (c < 3 || c >= 5) ? 8'h01 : 8'h00;
      step();
      if (c == 9)  check_eq("settle_e5", clean4, 8'h00);
      if (c == 10) check_eq("settle_e6", clean4, 8'h01);
    end

    // Independent bits: bit 7 at cycle 0, bit 3 at cycle 2.
    sw_raw = 8'h00;
    repeat (8) step();
    sw_raw = 8'h80;
    for (int e = 1; e <= 9; e++) begin
      if (e == 3) sw_raw = 8'h88;
      step();
      if (e == 6) begin
        check_eq("indep_clean_e6", clean4, 8'h80);
        check_eq("indep_chg_e6", chg4, 8'h80);
      end
      if (e == 7) check_eq("indep_chg_e7", chg4, 8'h00);
      if (e == 8) begin
        check_eq("indep_clean_e8", clean4, 8'h88);
        check_eq("indep_chg_e8", chg4, 8'h08);
      end
    end

    // Reset at edge 4 of a pending bit-2 transition; restarts from zero.
    sw_raw = 8'h00;
    do_reset();
    repeat (2) step();
    sw_raw = 8'h04;
    repeat (4) step();
    check_eq("mid_pending", clean4, 8'h00);
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 5) check_eq("mid_e5", clean4, 8'h00);
      if (e == 6) check_eq("mid_e6", clean4, 8'h04);
    end

    // D=1 follows raw with 3 edges of latency.
    sw_raw = 8'h3C;
    for (int e = 1; e <= 3; e++) begin
      step();
      if (e == 2) check_eq("d1_e2", clean1, 8'h04);
      if (e == 3) check_eq("d1_e3", clean1, 8'h3C);
    end

    // Random bouncing with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 6) == 0) sw_raw[b] = ~sw_raw[b];
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
